// File: rtl/inst_fetch_pkg.sv
// Shared constants and the FIFO entry type for the instruction-fetch front end.
package inst_fetch_pkg;
    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and same-cycle push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign o_empty = (count_q == '0);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && ((count_q != FULL_CNT) || do_pop);
    assign o_data  = mem_q[rptr_q];
    assign o_count = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem_q[wptr_q] <= i_data;
    end
endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: in-order imem reads, response FIFO, redirect squash.
// Define INST_FETCH_ALIGN_CHECK_EN to add o_misaligned and halt fetch on a misaligned redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_ren,
    output logic [31:0] o_imem_raddr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
`ifdef INST_FETCH_ALIGN_CHECK_EN
    output logic        o_misaligned,
`endif
    output logic [31:0] o_pc
);
    localparam int            AW      = $clog2(BUF_DEPTH);
    localparam logic [AW+1:0] CREDITS = BUF_DEPTH[AW+1:0];

    fetch_entry_t  head, push_entry;
    logic [31:0]   fetch_pc_q, fetch_pc_d, redirect_tgt, pcq_head;
    logic [AW:0]   fifo_count, pcq_count, drop_q, drop_d;
    logic [AW+1:0] credit_used;
    logic          fifo_empty, pcq_empty, run_q, halt;
    logic          resp, pop, issue, fifo_push;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign redirect_tgt = i_redirect_pc;
    assign misaligned_d = misaligned_q || (i_redirect && (i_redirect_pc[1:0] != 2'b00));
    assign halt         = misaligned_q;
    assign o_misaligned = misaligned_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) misaligned_q <= 1'b0;
        else          misaligned_q <= misaligned_d;
    end
`else
    assign redirect_tgt = i_redirect_pc & ~32'h3;
    assign halt         = 1'b0;
`endif

    // In-flight PC queue occupancy is the outstanding-read count; the credit
    // check counts a same-cycle pop so a full pipe keeps streaming.
    assign pop         = o_valid && !i_stall && !i_redirect;
    assign resp        = i_imem_rvalid && !pcq_empty;
    assign fifo_push   = resp && (drop_q == '0) && !i_redirect;
    assign credit_used = {1'b0, fifo_count} + {1'b0, pcq_count} - {{(AW+1){1'b0}}, pop};
    assign issue       = run_q && !halt && !i_redirect && (credit_used < CREDITS);
    assign push_entry  = '{pc: pcq_head, inst: i_imem_rdata};

    always_comb begin
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        if (i_redirect) begin
            drop_d = pcq_count - {{AW{1'b0}}, resp};
            if (!halt) fetch_pc_d = redirect_tgt;
        end else begin
            if (resp && (drop_q != '0)) drop_d = drop_q - {{AW{1'b0}}, 1'b1};
            if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_ADDR;
            drop_q     <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            run_q      <= 1'b1;
        end
    end

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_inst_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (fifo_push),
        .i_data  (push_entry),
        .i_pop   (pop),
        .o_data  (head),
        .o_count (fifo_count),
        .o_empty (fifo_empty)
    );

    fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pc_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (1'b0),
        .i_push  (issue),
        .i_data  (fetch_pc_q),
        .i_pop   (resp),
        .o_data  (pcq_head),
        .o_count (pcq_count),
        .o_empty (pcq_empty)
    );

    assign o_imem_ren   = issue;
    assign o_imem_raddr = fetch_pc_q;
    assign o_valid      = !fifo_empty;
    assign o_inst       = o_valid ? head.inst : NOP_INST;
    assign o_pc         = o_valid ? head.pc : fetch_pc_q;

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_rst_n) assert (!(i_imem_rvalid && pcq_empty))
            else $error("inst_fetch: read data returned with no read outstanding");
    end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: startup/stall vector table plus redirect, wrap,
// variable-latency and alignment sequences against an in-order memory model.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_imem_ren;
    logic [31:0] o_imem_raddr;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic        o_misaligned;
`endif

    int checks = 0;
    int failures = 0;

    inst_fetch #(.RESET_ADDR(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_ren    (o_imem_ren),
        .o_imem_raddr  (o_imem_raddr),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_inst        (o_inst),
`ifdef INST_FETCH_ALIGN_CHECK_EN
        .o_misaligned  (o_misaligned),
`endif
        .o_pc          (o_pc)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model and output scoreboard
    logic [31:0] rq_addr[$];
    int          rq_due[$];
    int          pcyc = 0;
    int          mem_lat = 1;
    int          gap_pct = 0;
    int          out_cnt = 0;
    logic        sb_en = 1'b0;
    logic [31:0] sb_pc = 32'h0;
    int          sb_pops = 0;

    initial begin
        logic        present;
        logic [31:0] ra;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                rq_addr.delete();
                rq_due.delete();
                out_cnt = 0;
            end else begin
                if (sb_en && o_valid && !i_stall && !i_redirect) begin
                    chk("sb_pc", o_pc, sb_pc);
                    chk("sb_inst", o_inst, mem_word(sb_pc));
                    sb_pc = sb_pc + 32'd4;
                    sb_pops++;
                end
                if (o_imem_ren) begin
                    rq_addr.push_back(o_imem_raddr);
                    rq_due.push_back(pcyc + 1 + mem_lat);
                    out_cnt++;
                end
                if (i_imem_rvalid) out_cnt--;
                if (sb_en) begin
                    checks++;
                    if (out_cnt > 2) begin
                        failures++;
                        $display("FAIL outstanding actual=%0d required<=2", out_cnt);
                    end
                end
            end
            @(posedge clk);
            pcyc++;
            #1;
            present = 1'b0;
            ra = 32'h0;
            if (rst_n && rq_addr.size() > 0) begin
                if (rq_due[0] <= pcyc + 1 && int'($urandom_range(0, 99)) >= gap_pct) begin
                    present = 1'b1;
                    ra = rq_addr.pop_front();
                    void'(rq_due.pop_front());
                end
            end
            i_imem_rvalid = present;
            i_imem_rdata  = present ? mem_word(ra) : 32'h0;
        end
    end

    typedef struct {
        logic        stall;
        logic        ren;
        logic [31:0] raddr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        int   pops0;

        // stall, ren, raddr, valid, pc  (1-cycle memory from reset release)
        vecs[0]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd4};
        vecs[3]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
        vecs[4]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd4};
        vecs[5]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
        vecs[6]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
        vecs[7]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
        vecs[8]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
        vecs[9]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd8};
        vecs[10] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8};
        vecs[11] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12};
        vecs[12] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
        vecs[13] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd20};

        rst_n = 1'b0;
        i_stall = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = 32'h0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ren", o_imem_ren, 1'b0);
        chk("rst_raddr", o_imem_raddr, 32'h0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_inst", o_inst, 32'h0000_0013);
        chk("rst_pc", o_pc, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            i_stall = vecs[i].stall;
            #1;
            chk($sformatf("vec%0d_ren", i), o_imem_ren, vecs[i].ren);
            chk($sformatf("vec%0d_raddr", i), o_imem_raddr, vecs[i].raddr);
            chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].valid);
            chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].pc);
            chk($sformatf("vec%0d_inst", i), o_inst,
                vecs[i].valid ? mem_word(vecs[i].pc) : 32'h0000_0013);
            if (i == 13) begin
                sb_pc = 32'd20;
                sb_en = 1'b1;
            end
            @(negedge clk);
        end

        // Redirect with two reads in flight: both responses must be squashed
        mem_lat = 3;
        for (int k = 0; k < 40; k++) begin
            if (out_cnt == 2) break;
            @(negedge clk);
        end
        chk("redir_outstanding", out_cnt, 2);
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0100;
        sb_pc = 32'h0000_0100;
        #1;
        chk("redir_no_issue", o_imem_ren, 1'b0);
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        chk("redir_valid_low", o_valid, 1'b0);
        chk("redir_raddr", o_imem_raddr, 32'h0000_0100);
        for (int k = 0; k < 20; k++) begin
            if (o_valid) break;
            @(negedge clk);
            #1;
        end
        chk("redir_first_valid", o_valid, 1'b1);
        chk("redir_first_pc", o_pc, 32'h0000_0100);
        repeat (6) @(negedge clk);

        // PC wrap at the top of the address space
        mem_lat = 1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF8;
        sb_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        i_redirect = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_imem_ren && o_imem_raddr == 32'hFFFF_FFFC) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wrap_seen_fffffffc", found, 1'b1);
        @(negedge clk);
        #1;
        chk("wrap_raddr", o_imem_raddr, 32'h0000_0000);
        repeat (8) @(negedge clk);

        // Latency 3 with random response gaps and random stalls
        mem_lat = 3;
        gap_pct = 40;
        pops0 = sb_pops;
        for (int k = 0; k < 300; k++) begin
            i_stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        i_stall = 1'b0;
        gap_pct = 0;
        checks++;
        if (sb_pops - pops0 <= 40) begin
            failures++;
            $display("FAIL gap_throughput actual=%0d required>40", sb_pops - pops0);
        end
        repeat (10) @(negedge clk);

        // Misaligned redirect target
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0102;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        sb_en = 1'b0;
        chk("mis_before", o_misaligned, 1'b0);
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        chk("mis_flag", o_misaligned, 1'b1);
        chk("mis_pc", o_pc, 32'h0000_0102);
        chk("mis_valid", o_valid, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mis_halt%0d", k), o_imem_ren, 1'b0);
            chk($sformatf("mis_sticky%0d", k), o_misaligned, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mis_cleared_by_reset", o_misaligned, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("mis_restart_ren", o_imem_ren, 1'b1);
`else
        sb_pc = 32'h0000_0100;
        @(negedge clk);
        i_redirect = 1'b0;
        #1;
        chk("align_raddr", o_imem_raddr, 32'h0000_0100);
        for (int k = 0; k < 20; k++) begin
            if (o_valid) break;
            @(negedge clk);
            #1;
        end
        chk("align_first_pc", o_pc, 32'h0000_0100);
        repeat (6) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
